// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: widths, the NOP encoding and the IF/ID payload type.
package arm_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/pc_register.sv
// Program counter register with synchronous reset and load enable.
module pc_register #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, IF/ID register and fetch/flush counters.
module fetch_stage
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [31:0]        fetch_count,
  output logic [15:0]        flush_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_aligned;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_en;

  assign pc_plus4       = pc + ADDR_W'(4);
  assign branch_aligned = {branch_addr[ADDR_W-1:2], 2'b00};
  assign pc_next        = branch_taken ? branch_aligned : pc_plus4;
  // A taken branch must redirect even while decode is stalling.
  assign pc_en          = ~freeze | branch_taken;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .rst     (rst),
    .en      (pc_en),
    .pc_next (pc_next),
    .pc      (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_pc    <= '0;
      if_id_instr <= INSTR_W'(NOP_INSTR);
      if_id_valid <= 1'b0;
      fetch_count <= '0;
      flush_count <= '0;
    end else if (branch_taken) begin
      if_id_pc    <= '0;
      if_id_instr <= INSTR_W'(NOP_INSTR);
      if_id_valid <= 1'b0;
      if (flush_count != 16'hFFFF) begin
        flush_count <= flush_count + 16'd1;
      end
    end else if (!freeze) begin
      if_id_pc    <= pc_plus4;
      if_id_instr <= imem_data;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage against a synthetic ROM.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic [15:0] flush_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // ROM word encodes its own address so captured words are easy to predict.
  assign imem_data = {16'hC0DE, imem_addr[15:0]};

  fetch_stage #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fetch_count  (fetch_count),
    .flush_count  (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] a, input logic [31:0] p,
                            input logic [31:0] ins, input logic v, input logic [31:0] fc);
    check({tag, ".imem_addr"}, imem_addr, a);
    check({tag, ".if_id_pc"}, if_id_pc, p);
    check({tag, ".if_id_instr"}, if_id_instr, ins);
    check({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    check({tag, ".fetch_count"}, fetch_count, fc);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    step();
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("reset.flush_count", {16'b0, flush_count}, 32'd0);
    rst = 1'b0;

    // Sequential fetch from reset.
    step(); check_ifid("seq1", 32'h4, 32'h4, 32'hC0DE0000, 1'b1, 32'd1);
    step(); check_ifid("seq2", 32'h8, 32'h8, 32'hC0DE0004, 1'b1, 32'd2);
    step(); check_ifid("seq3", 32'hC, 32'hC, 32'hC0DE0008, 1'b1, 32'd3);
    step(); check_ifid("seq4", 32'h10, 32'h10, 32'hC0DE000C, 1'b1, 32'd4);

    // Freeze for three edges at PC 0x10.
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_ifid("freeze", 32'h10, 32'h10, 32'hC0DE000C, 1'b1, 32'd4);
    end
    freeze = 1'b0;
    step(); check_ifid("unfreeze", 32'h14, 32'h14, 32'hC0DE0010, 1'b1, 32'd5);
    step(); step(); step();
    check_ifid("pre_branch", 32'h20, 32'h20, 32'hC0DE001C, 1'b1, 32'd8);

    // Taken branch to an unaligned target.
    branch_taken = 1'b1; branch_addr = 32'h0000_0062;
    step(); check_ifid("branch", 32'h60, 32'h0, 32'h0, 1'b0, 32'd8);
    check("branch.flush_count", {16'b0, flush_count}, 32'd1);
    branch_taken = 1'b0;
    step(); check_ifid("target", 32'h64, 32'h64, 32'hC0DE0060, 1'b1, 32'd9);

    // Branch and freeze together: branch wins.
    branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h80;
    step(); check_ifid("br_frz", 32'h80, 32'h0, 32'h0, 1'b0, 32'd9);
    check("br_frz.flush_count", {16'b0, flush_count}, 32'd2);
    freeze = 1'b0;

    // PC wrap at the top of the address space.
    branch_addr = 32'hFFFF_FFFC;
    step(); check("wrap.imem_addr0", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step(); check_ifid("wrap", 32'h0, 32'h0, 32'hC0DEFFFC, 1'b1, 32'd10);

    // Reset while frozen at PC 0x40.
    branch_taken = 1'b1; branch_addr = 32'h40;
    step(); check("pre_rst.imem_addr", imem_addr, 32'h40);
    check("pre_rst.flush_count", {16'b0, flush_count}, 32'd4);
    branch_taken = 1'b0; freeze = 1'b1; rst = 1'b1;
    step(); check_ifid("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("mid_rst.flush_count", {16'b0, flush_count}, 32'd0);
    rst = 1'b0; freeze = 1'b0;
    step(); check_ifid("post_rst", 32'h4, 32'h4, 32'hC0DE0000, 1'b1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
